// File: rtl/mult_seq_if.sv
// Handshake/operand bundle for mult_seq. The master side issues requests and the
// slave side (the multiplier) returns result, busy and multiplier_done.
`ifndef WORD
`define WORD 64
`endif

interface mult_seq_if #(
  parameter int WIDTH = `WORD
);
  logic             mult_start;
  logic [1:0]       mult_mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             multiplier_done;

  modport master (
    output mult_start, mult_mode, op_a, op_b,
    input  result, busy, multiplier_done
  );

  modport slave (
    input  mult_start, mult_mode, op_a, op_b,
    output result, busy, multiplier_done
  );
endinterface

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier: MUL / SMULH / UMULH, WIDTH must be even.
// Define MULT_RADIX4_EN to retire two multiplier bits per cycle (same results).
`ifndef WORD
`define WORD 64
`endif

module mult_seq #(
  parameter int WIDTH = `WORD
) (
  input logic      clk,
  input logic      reset,
  mult_seq_if.slave bus
);

`ifdef MULT_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int ITER = WIDTH / STEP;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [1:0] MODE_SMULH = 2'b01;
  localparam logic [1:0] MODE_UMULH = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [1:0]         mode_q;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
`ifdef MULT_RADIX4_EN
  logic [2*WIDTH-1:0] mcand3;
`endif
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;
  logic               done_q;

  logic               is_smulh;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_sel;

  // Operand conditioning at start: SMULH works on magnitudes, so the most
  // negative value becomes 2^(WIDTH-1) as an unsigned WIDTH-bit quantity.
  always_comb begin
    is_smulh = (bus.mult_mode == MODE_SMULH);
    a_mag    = (is_smulh && bus.op_a[WIDTH-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
    b_mag    = (is_smulh && bus.op_b[WIDTH-1]) ? (~bus.op_b + 1'b1) : bus.op_b;
    a_ext    = {{WIDTH{1'b0}}, a_mag};
  end

  // Partial product for this iteration and the result as it will be on the
  // final edge (acc_next already includes the last addend).
  always_comb begin
    addend = '0;
`ifdef MULT_RADIX4_EN
    case (mplier[1:0])
      2'b01:   addend = mcand;
      2'b10:   addend = mcand << 1;
      2'b11:   addend = mcand3;
      default: addend = '0;
    endcase
`else
    if (mplier[0]) addend = mcand;
`endif
    acc_next = acc + addend;
    prod     = neg ? (~acc_next + 1'b1) : acc_next;
    case (mode_q)
      MODE_SMULH: res_sel = prod[2*WIDTH-1:WIDTH];
      MODE_UMULH: res_sel = acc_next[2*WIDTH-1:WIDTH];
      default:    res_sel = acc_next[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
`ifdef MULT_RADIX4_EN
      mcand3   <= '0;
`endif
      mplier   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.mult_start) begin
            state  <= BUSY;
            busy_q <= 1'b1;
            mode_q <= bus.mult_mode;
            neg    <= is_smulh & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            cnt    <= CW'(ITER);
            acc    <= '0;
            mcand  <= a_ext;
`ifdef MULT_RADIX4_EN
            mcand3 <= (a_ext << 1) + a_ext;
`endif
            mplier <= b_mag;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << STEP;
`ifdef MULT_RADIX4_EN
          mcand3 <= mcand3 << STEP;
`endif
          mplier <= mplier >> STEP;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state    <= DONE;
            result_q <= res_sel;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result          = result_q;
  assign bus.busy            = busy_q;
  assign bus.multiplier_done = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed, table-driven bench for mult_seq (64-bit), plus back-to-back and
// reset-abort sequences. Honours MULT_RADIX4_EN for the expected latency.
module tb_mult_seq;
  localparam int W = 64;
`ifdef MULT_RADIX4_EN
  localparam int LAT = W / 2 + 1;
`else
  localparam int LAT = W + 1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[14];

  // Issue one operation, scramble inputs while busy, wait (bounded) for done.
  task automatic run_op(input logic [1:0] mode, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output int bcyc,
                        output bit pulse_ok);
    @(negedge clk);
    bus.mult_mode  = mode;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.mult_start = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    bus.op_a       = ~a;
    bus.op_b       = a ^ b;
    bus.mult_mode  = ~mode;
    lat  = 1;
    bcyc = 0;
    while (!bus.multiplier_done && lat < 300) begin
      if (bus.busy) bcyc++;
      if (lat == 5) bus.mult_start = 1'b1;
      if (lat == 6) bus.mult_start = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = bus.result;
    @(negedge clk);
    pulse_ok = !bus.multiplier_done && !bus.busy && (bus.result === res);
  endtask

  logic [63:0] res;
  int          lat;
  int          bcyc;
  bit          pulse_ok;
  bit          hold_ok;
  int          dcount;

  initial begin
    vecs[0]  = '{"mul_7x6",        2'b00, 64'd7,                 64'd6,                 64'd42};
    vecs[1]  = '{"smulh_m1xm1",    2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[2]  = '{"smulh_m1x2",     2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3]  = '{"smulh_minxmin",  2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[4]  = '{"umulh_ffx2",     2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                 64'd1};
    vecs[5]  = '{"mul_ffx2",       2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[6]  = '{"mode11_7x6",     2'b11, 64'd7,                 64'd6,                 64'd42};
    vecs[7]  = '{"umulh_zero",     2'b10, 64'd0,                 64'd0,                 64'd0};
    vecs[8]  = '{"mul_0xff",       2'b00, 64'd0,                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[9]  = '{"smulh_5xm3",     2'b01, 64'd5,                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[10] = '{"smulh_minx1",    2'b01, 64'h8000_0000_0000_0000, 64'd1,                 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[11] = '{"smulh_minxm1",   2'b01, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[12] = '{"umulh_ffxff",    2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[13] = '{"mul_big",        2'b00, 64'h1234_5678_9ABC_DEF1, 64'h10,                64'h2345_6789_ABCD_EF10};

    reset          = 1'b1;
    bus.mult_start = 1'b0;
    bus.mult_mode  = 2'b00;
    bus.op_a       = '0;
    bus.op_b       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", bus.result, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.multiplier_done}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].mode, vecs[i].a, vecs[i].b, res, lat, bcyc, pulse_ok);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(LAT));
      check({vecs[i].name, "_busycyc"}, 64'(bcyc), 64'(LAT - 1));
      check({vecs[i].name, "_pulse"}, {63'd0, pulse_ok}, 64'd1);
    end

    // Back-to-back: restart with 9x9 mid-operation is ignored, then start in DONE.
    @(negedge clk);
    bus.mult_mode  = 2'b00;
    bus.op_a       = 64'd5;
    bus.op_b       = 64'd5;
    bus.mult_start = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    lat = 1;
    while (!bus.multiplier_done && lat < 300) begin
      if (lat == 10) begin
        bus.op_a       = 64'd9;
        bus.op_b       = 64'd9;
        bus.mult_start = 1'b1;
      end
      if (lat == 11) bus.mult_start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("b2b_first_result", bus.result, 64'd25);
    check("b2b_first_latency", 64'(lat), 64'(LAT));
    bus.op_a       = 64'd3;
    bus.op_b       = 64'd4;
    bus.mult_start = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    check("b2b_restart_busy", {62'd0, bus.busy, bus.multiplier_done}, 64'd2);
    lat     = 1;
    hold_ok = 1'b1;
    while (!bus.multiplier_done && lat < 300) begin
      if (bus.result !== 64'd25) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("b2b_result_hold", {63'd0, hold_ok}, 64'd1);
    check("b2b_second_result", bus.result, 64'd12);
    check("b2b_second_latency", 64'(lat), 64'(LAT));

    // Reset 30 cycles into an operation aborts it.
    @(negedge clk);
    bus.op_a       = 64'd7;
    bus.op_b       = 64'd6;
    bus.mult_start = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_result", bus.result, 64'd0);
    dcount = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.multiplier_done) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);

    run_op(2'b00, 64'd7, 64'd6, res, lat, bcyc, pulse_ok);
    check("post_abort_result", res, 64'd42);
    check("post_abort_latency", 64'(lat), 64'(LAT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default `WORD (64), giving the operand and result width; it must be even.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port mult_start, input, 1, a request to begin a multiply, sampled on clk.
REQ-005 The block SHALL have port mult_mode, input, 2, the operation select:
- 00 = MUL (low WIDTH bits);
- 01 = SMULH (high WIDTH bits, signed x signed);
- 10 = UMULH (high WIDTH bits, unsigned x unsigned);
- 11 = same as MUL.
REQ-006 The block SHALL have port op_a, input, WIDTH, the multiplicand (Rn data).
REQ-007 The block SHALL have port op_b, input, WIDTH, the multiplier (Rm data).
REQ-008 The block SHALL have port result, output, WIDTH, the registered product selected by mode.
REQ-009 The block SHALL have port busy, output, 1, high while iterating.
REQ-010 The block SHALL have port multiplier_done, output, 1, a one-cycle pulse indicating result is valid.

Function
REQ-011 The block SHALL implement FSM states IDLE, BUSY and DONE, with these transitions:
- IDLE -> BUSY on mult_start;
- BUSY -> DONE when the iteration count expires;
- DONE -> BUSY on mult_start, else DONE -> IDLE.
REQ-012 On an accepted start, the block SHALL latch mode, |op_a| and |op_b| (magnitudes only for SMULH; raw bits otherwise), plus neg = sign(op_a) XOR sign(op_b) for SMULH.
REQ-013 The block SHALL clear a 2*WIDTH accumulator and load the iteration counter at start.
REQ-014 In BUSY, each edge SHALL retire 1 multiplier bit by shift-add: if the LSB of the shifted multiplier is 1, add the multiplicand shifted left by the iteration index into the 2*WIDTH accumulator.
REQ-015 Iterations per operation SHALL be WIDTH (64 by default).
REQ-016 On the final iteration edge, the block SHALL load result as follows:
- MUL: accumulator[WIDTH-1:0];
- UMULH: accumulator[2W-1:W];
- SMULH: upper half of (neg ? two's-complement negate of the full 2*WIDTH value : accumulator).
REQ-017 Latency SHALL be: multiplier_done high in the cycle beginning WIDTH+1 edges after the edge that sampled mult_start; multiplier_done is high in DONE only.
REQ-018 busy SHALL be high exactly in BUSY.
REQ-019 result SHALL hold its value from the DONE edge until the next completion or reset, and SHALL not change during BUSY.
REQ-020 mult_start in BUSY SHALL be ignored, with no queuing; the operand and mode changes are ignored.
REQ-021 mult_start in DONE SHALL be accepted in the same cycle that multiplier_done pulses (back-to-back operation).
REQ-022 The most-negative operand in SMULH SHALL be handled with a WIDTH-bit magnitude treated as unsigned (no overflow).
REQ-023 Operands of zero SHALL still take full latency; there is no early termination.

Reset
REQ-024 While reset is high at an edge, the block SHALL force state = IDLE, result = 0, busy = 0, multiplier_done = 0, accumulator = 0 and counter = 0.
REQ-025 Reset SHALL have priority over mult_start; a reset during BUSY aborts the operation, and no multiplier_done pulse follows.

Configuration
REQ-026 The block SHALL support macro MULT_RADIX4_EN:
- When defined, each BUSY edge retires 2 multiplier bits, adding 0, 1x, 2x or 3x the multiplicand (3x precomputed at start); iterations = WIDTH/2 and latency = WIDTH/2+1 edges.
- When undefined, the block uses radix-2 per REQ-014/REQ-017.
- Results are identical in both builds.

Verification
REQ-027 MUL: op_a=7, op_b=6, start -> result=42, multiplier_done pulses 65 edges after start, busy high 64 cycles.
REQ-028 SMULH: op_a=-1, op_b=-1 -> result=0; then op_a=-1, op_b=2 -> result=0xFFFF_FFFF_FFFF_FFFF; op_a=0x8000_0000_0000_0000, op_b=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000.
REQ-029 UMULH: op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=2 -> result=1; MUL on the same operands -> result=0xFFFF_FFFF_FFFF_FFFE.
REQ-030 Start 5x5, re-assert start with 9x9 at cycle 10 -> result=25, single done pulse; then start in the DONE cycle with 3x4 -> result=12 after a further 65 edges.
REQ-031 Start 7x6, assert reset at cycle 30 for one edge -> busy=0, result=0, no multiplier_done within 200 cycles.
REQ-032 With MULT_RADIX4_EN, rerun REQ-027 to REQ-029 -> same results, multiplier_done 33 edges after start.
